// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state types and constants for the on-chip I2C master and target.
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   typedef enum logic [2:0] {IDLE, ADDR, ACK, REG, WRITE, READ, IGNORE} i2c_target_state_t;
   typedef enum logic [2:0] {M_IDLE, M_START, M_ADDR, M_REG, M_WRITE, M_READ, M_ACK, M_STOP} i2c_master_state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises scl/sda into clk and derives clock edges and START/STOP.
module i2c_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start_det,
   output logic o_stop_det
);
   logic [1:0] r_scl_sync, r_sda_sync;
   logic       r_scl_prev, r_sda_prev;
   logic       w_scl, w_sda;
   assign w_scl       = r_scl_sync[1];
   assign w_sda       = r_sda_sync[1];
   assign o_sda       = w_sda;
   assign o_scl_rise  = w_scl & ~r_scl_prev;
   assign o_scl_fall  = ~w_scl & r_scl_prev;
   assign o_start_det = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
   assign o_stop_det  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
   // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i_scl};
         r_sda_sync <= {r_sda_sync[0], i_sda};
         r_scl_prev <= w_scl;
         r_sda_prev <= w_sda;
      end
   end
endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit I2C target bridging bus transfers onto a simple register bus.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] DEVICE_ADDR         = 7'h42,
   parameter int                    REGISTER_ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH          = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   inout  wire                            scl,
   inout  wire                            sda,
   output logic [REGISTER_ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0]          reg_wdata,
   output logic                           reg_we,
   output logic                           reg_re,
   input  logic [DATA_WIDTH-1:0]          reg_rdata,
   output logic                           busy
);
   localparam int RAW = REGISTER_ADDR_WIDTH;
   localparam int PB  = RAW / 8;
   localparam int PBW = $clog2(PB + 1);
   i2c_target_state_t     r_state, w_state_nxt, r_ack_nxt;
   logic [DATA_WIDTH-1:0] r_shift, r_reg_wdata, w_byte;
   logic [3:0]            r_bit_cnt;
   logic [RAW-1:0]        r_ptr, r_reg_addr;
   logic [PBW-1:0]        r_pb_cnt;
   logic                  r_sda_oe, r_busy, r_reg_we, r_reg_re, r_load;
   logic                  w_sda, w_rise, w_fall, w_start, w_stop, w_match, w_byte_done;
   i2c_line_sync u_sync (
      .clk        (clk),
      .reset      (reset),
      .i_scl      (scl),
      .i_sda      (sda),
      .o_sda      (w_sda),
      .o_scl_rise (w_rise),
      .o_scl_fall (w_fall),
      .o_start_det(w_start),
      .o_stop_det (w_stop)
   );
   assign sda         = r_sda_oe ? 1'b0 : 1'bz;
   assign reg_addr    = r_reg_addr;
   assign reg_wdata   = r_reg_wdata;
   assign reg_we      = r_reg_we;
   assign reg_re      = r_reg_re;
   assign busy        = r_busy;
   assign w_byte      = {r_shift[DATA_WIDTH-2:0], w_sda};
   assign w_match     = w_byte[7:1] == DEVICE_ADDR;
   assign w_byte_done = w_rise && r_bit_cnt == 4'd7;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end
   always_comb begin
      w_state_nxt = r_state;
      if (w_start) w_state_nxt = ADDR;
      else if (w_stop) w_state_nxt = IDLE;
      else case (r_state)
         ADDR:        if (w_byte_done) w_state_nxt = w_match ? ACK : IGNORE;
         ACK:         if (w_fall && r_sda_oe) w_state_nxt = r_ack_nxt;
         REG, WRITE:  if (w_byte_done) w_state_nxt = ACK;
         READ:        if (w_rise && r_bit_cnt == 4'd8 && w_sda) w_state_nxt = IGNORE;
         default:     ;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_ptr       <= '0;
         r_pb_cnt    <= '0;
         r_ack_nxt   <= IDLE;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_reg_we    <= 1'b0;
         r_reg_re    <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
         r_load      <= 1'b0;
      end else begin
         r_reg_we <= 1'b0;
         r_reg_re <= 1'b0;
         r_load   <= r_reg_re;
         if (w_start || w_stop) begin
            r_bit_cnt <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
         end else case (r_state)
            ADDR, REG, WRITE: if (w_rise) begin
               r_shift   <= w_byte;
               r_bit_cnt <= r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd7) begin
                  if (r_state == ADDR && w_match) begin
                     r_busy    <= 1'b1;
                     r_ack_nxt <= w_sda ? READ : REG;
                     r_pb_cnt  <= '0;
                  end
                  if (r_state == REG) begin
                     r_ptr     <= RAW'({r_ptr, w_byte});
                     r_pb_cnt  <= r_pb_cnt + PBW'(1);
                     r_ack_nxt <= (r_pb_cnt == PBW'(PB - 1)) ? WRITE : REG;
                  end
                  if (r_state == WRITE) begin
                     r_reg_we    <= 1'b1;
                     r_reg_addr  <= r_ptr;
                     r_reg_wdata <= w_byte;
                     r_ptr       <= r_ptr + RAW'(1);
                  end
               end
            end
            // First fall drives the ACK, second fall ends it (and starts read data).
            ACK: if (w_fall) begin
               if (!r_sda_oe) begin
                  r_sda_oe <= 1'b1;
                  if (r_ack_nxt == READ) begin
                     r_reg_re   <= 1'b1;
                     r_reg_addr <= r_ptr;
                  end
               end else begin
                  r_bit_cnt <= '0;
                  r_sda_oe  <= (r_ack_nxt == READ) && !r_shift[DATA_WIDTH-1];
                  if (r_ack_nxt == READ) r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
               end
            end
            READ: begin
               if (w_rise) begin
                  r_bit_cnt <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd8 && !w_sda) begin
                     r_reg_re   <= 1'b1;
                     r_reg_addr <= r_ptr;
                  end
               end
               if (w_fall) begin
                  r_sda_oe <= (r_bit_cnt < 4'd8) && !r_shift[DATA_WIDTH-1];
                  if (r_bit_cnt < 4'd8) r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
               end
            end
            default: ;
         endcase
         if (r_load) begin
            r_shift <= reg_rdata;
            r_ptr   <= r_ptr + RAW'(1);
         end
      end
   end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master driving directed transfers into i2c_target.
module tb_i2c_target;
   localparam int Q = 60;
   logic       clk = 1'b0, reset = 1'b1, r_scl = 1'b1, r_sda_low = 1'b0;
   logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00, pat [256];
   logic       reg_we, reg_re, busy;
   wire        scl, sda;
   logic [7:0] we_a[$], we_d[$], re_a[$];
   int         n_run = 0, n_fail = 0, n_both = 0, n_glitch = 0;
   logic       p_scl = 1'b1, p_sda = 1'b1, p_low = 1'b0;
   logic [7:0] rd;
   assign scl = r_scl;
   assign sda = r_sda_low ? 1'b0 : 1'bz;
   pullup (sda);
   always #5 clk = ~clk;
   i2c_target dut (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda      (sda),
      .reg_addr (reg_addr),
      .reg_wdata(reg_wdata),
      .reg_we   (reg_we),
      .reg_re   (reg_re),
      .reg_rdata(reg_rdata),
      .busy     (busy)
   );
   // Register bus model with a 1-cycle read latency.
   always @(posedge clk) if (reg_re) reg_rdata <= pat[reg_addr];
   always @(negedge clk) begin
      if (reg_we) begin
         we_a.push_back(reg_addr);
         we_d.push_back(reg_wdata);
      end
      if (reg_re) re_a.push_back(reg_addr);
      if (reg_we && reg_re) n_both <= n_both + 1;
      if (!reset && scl && p_scl && r_sda_low == p_low && sda !== p_sda) n_glitch <= n_glitch + 1;
      p_scl <= scl;
      p_sda <= sda;
      p_low <= r_sda_low;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic bus_start();
      r_sda_low = 1'b0; #(Q);
      r_scl = 1'b1;     #(Q);
      r_sda_low = 1'b1; #(Q);
      r_scl = 1'b0;     #(Q);
   endtask
   task automatic bus_stop();
      r_sda_low = 1'b1; #(Q);
      r_scl = 1'b1;     #(Q);
      r_sda_low = 1'b0; #(Q);
   endtask
   task automatic put_bit(input logic b);
      r_sda_low = !b; #(Q);
      r_scl = 1'b1;   #(2*Q);
      r_scl = 1'b0;   #(Q);
   endtask
   task automatic get_bit(output logic b);
      r_sda_low = 1'b0; #(Q);
      r_scl = 1'b1;     #(Q);
      b = sda;          #(Q);
      r_scl = 1'b0;     #(Q);
   endtask
   task automatic put_byte(input logic [7:0] d, input logic exp_ack, input string tag);
      logic a;
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(a);
      chk(tag, 32'(!a), 32'(exp_ack));
   endtask
   task automatic get_byte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(!ack);
   endtask
   task automatic clear_logs();
      we_a.delete();
      we_d.delete();
      re_a.delete();
   endtask
   initial begin
      for (int i = 0; i < 256; i++) pat[i] = 8'h00;
      #(Q) reset = 1'b0;
      #(Q);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we", 32'(reg_we), 0);
      chk("rst_re", 32'(reg_re), 0);
      chk("rst_addr", 32'(reg_addr), 0);
      chk("rst_wdata", 32'(reg_wdata), 0);
      chk("rst_sda", 32'(sda), 1);
      // Single-byte write
      clear_logs();
      bus_start();
      put_byte(8'h84, 1'b1, "t1_ack_addr");
      put_byte(8'h10, 1'b1, "t1_ack_ptr");
      put_byte(8'hA5, 1'b1, "t1_ack_data");
      chk("t1_busy_before_stop", 32'(busy), 1);
      bus_stop();
      #(Q);
      chk("t1_busy_after_stop", 32'(busy), 0);
      chk("t1_we_count", we_a.size(), 1);
      chk("t1_we_addr", 32'(we_a[0]), 32'h10);
      chk("t1_we_data", 32'(we_d[0]), 32'hA5);
      // Pointer write, repeated START, single-byte read with NACK
      pat[8'h10] = 8'h3C;
      clear_logs();
      bus_start();
      put_byte(8'h84, 1'b1, "t2_ack_addr_w");
      put_byte(8'h10, 1'b1, "t2_ack_ptr");
      bus_start();
      put_byte(8'h85, 1'b1, "t2_ack_addr_r");
      get_byte(1'b0, rd);
      chk("t2_rdata", 32'(rd), 32'h3C);
      chk("t2_sda_released", 32'(sda), 1);
      bus_stop();
      chk("t2_re_count", re_a.size(), 1);
      chk("t2_re_addr", 32'(re_a[0]), 32'h10);
      chk("t2_we_count", we_a.size(), 0);
      // Wrong address is ignored until STOP
      clear_logs();
      bus_start();
      put_byte(8'h86, 1'b0, "t3_nack_addr");
      chk("t3_busy", 32'(busy), 0);
      put_byte(8'h55, 1'b0, "t3_nack_data");
      bus_stop();
      chk("t3_strobes", we_a.size() + re_a.size(), 0);
      // Burst write wrapping the pointer
      clear_logs();
      bus_start();
      put_byte(8'h84, 1'b1, "t4_ack_addr");
      put_byte(8'hFE, 1'b1, "t4_ack_ptr");
      put_byte(8'h11, 1'b1, "t4_ack_d0");
      put_byte(8'h22, 1'b1, "t4_ack_d1");
      put_byte(8'h33, 1'b1, "t4_ack_d2");
      bus_stop();
      chk("t4_we_count", we_a.size(), 3);
      chk("t4_we_a0", 32'(we_a[0]), 32'hFE);
      chk("t4_we_a1", 32'(we_a[1]), 32'hFF);
      chk("t4_we_a2", 32'(we_a[2]), 32'h00);
      chk("t4_we_d0", 32'(we_d[0]), 32'h11);
      chk("t4_we_d2", 32'(we_d[2]), 32'h33);
      // Reset in the middle of a read while the target is driving SDA low
      pat[8'h20] = 8'h0F;
      clear_logs();
      bus_start();
      put_byte(8'h84, 1'b1, "t5_ack_addr_w");
      put_byte(8'h20, 1'b1, "t5_ack_ptr");
      bus_start();
      put_byte(8'h85, 1'b1, "t5_ack_addr_r");
      for (int i = 0; i < 3; i++) get_bit(rd[0]);
      r_sda_low = 1'b0; #(Q);
      r_scl = 1'b1;     #(Q);
      chk("t5_bit4_driven", 32'(sda), 0);
      chk("t5_busy_pre", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("t5_sda_released", 32'(sda), 1);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_re", 32'(reg_re), 0);
      chk("t5_addr", 32'(reg_addr), 0);
      #(Q) reset = 1'b0;
      #(Q) r_scl = 1'b0;
      #(Q);
      bus_stop();
      clear_logs();
      bus_start();
      put_byte(8'h84, 1'b1, "t5_ack_addr_after");
      put_byte(8'h30, 1'b1, "t5_ack_ptr_after");
      put_byte(8'h77, 1'b1, "t5_ack_data_after");
      bus_stop();
      chk("t5_we_count", we_a.size(), 1);
      chk("t5_we_addr", 32'(we_a[0]), 32'h30);
      chk("t5_we_data", 32'(we_d[0]), 32'h77);
      // Repeated START keeps the pointer; two-byte read exercises prefetch
      pat[8'h50] = 8'hC3;
      pat[8'h51] = 8'h5A;
      clear_logs();
      bus_start();
      put_byte(8'h84, 1'b1, "t6_ack_addr_w");
      put_byte(8'h50, 1'b1, "t6_ack_ptr");
      bus_start();
      put_byte(8'h85, 1'b1, "t6_ack_addr_r");
      get_byte(1'b1, rd);
      chk("t6_rdata0", 32'(rd), 32'hC3);
      get_byte(1'b0, rd);
      chk("t6_rdata1", 32'(rd), 32'h5A);
      bus_stop();
      chk("t6_re_count", re_a.size(), 2);
      chk("t6_re_a0", 32'(re_a[0]), 32'h50);
      chk("t6_re_a1", 32'(re_a[1]), 32'h51);
      chk("t6_we_count", we_a.size(), 0);
      chk("we_re_overlap", n_both, 0);
      chk("sda_stable_scl_high", n_glitch, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
